regbank_write_arbiter: RTL
==========================

# regbank_write_arbiter

Round-robin arbiter sharing the single write port of the 8×8 register bank (`register8_bank`) among `N_REQ` independent requesters. Each requester uses a valid/ready handshake. A requester may lock the port for a bounded burst. The arbiter drives registered `write_enable`/`write_addr`/`write_data` straight into the bank and drops writes to hardwired-zero register X0 before they reach it.

## Interface
- `N_REQ`, 4: number of requesters (2..8)
- `ADDR_W`, 3: register address width
- `DATA_W`, 8: register data width
- `LOCK_MAX`, 8: max transfers per locked burst (≥1)

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: asynchronous, active-high reset
- `req_valid` in N_REQ: requester i has a write pending
- `req_lock` in N_REQ: requester i asks to keep the port after this transfer
- `req_addr` in N_REQ*ADDR_W: packed, slice i = address of requester i
- `req_data` in N_REQ*DATA_W: packed, slice i = data of requester i
- `req_ready` out N_REQ: one-hot-or-zero grant; transfer when `req_valid[i] & req_ready[i]`
- `write_enable` out 1: bank write strobe, registered
- `write_addr` out ADDR_W: bank write address, registered
- `write_data` out DATA_W: bank write data, registered
- `busy` out 1: high while in LOCK
- `owner` out $clog2(N_REQ): last granted requester index

## Operation
- FSM states: ARB (open round-robin) and LOCK (port reserved for `owner`).
- ARB: scan from `rr_ptr` upward, with wrap-around, for the first `req_valid`. Assert `req_ready` for that index only. With no valid request, all ready bits are 0.
- On a transfer by requester i:
  - capture its addr/data into the output registers;
  - `owner` <= i;
  - `rr_ptr` <= (i+1) mod N_REQ.
- ARB → LOCK: transfer with `req_lock[i]`=1 and `LOCK_MAX`>1. The burst counter loads 1.
- LOCK:
  - `req_ready[owner]` = `req_valid[owner]`; all other ready bits are 0.
  - Each owner transfer increments the burst counter.
- LOCK → ARB on any of:
  - owner transfers with `req_lock`=0;
  - owner transfer makes the burst counter reach `LOCK_MAX` (forced release);
  - `req_lock[owner]`=0 while `req_valid[owner]`=0.
- On leaving LOCK, `rr_ptr` = owner+1, so the next grant goes to a different requester when one is waiting.
- X0 rule: a transfer with address 0 completes the handshake but produces `write_enable`=0 next cycle. `write_addr` and `write_data` still update.
- Inputs are sampled only at the transfer edge; they are don't-care otherwise.

## Timing
- `req_ready` is combinational from state, `rr_ptr`, `owner`, and `req_valid`/`req_lock`. There is no path from `req_addr` or `req_data` to ready.
- Transfer at edge k → `write_enable`/`write_addr`/`write_data` valid for exactly cycle k+1. `write_enable` is a 1-cycle pulse per transfer.
- Throughput: one transfer per cycle, back-to-back, including across requester switches.
- Reset values:
  - `write_enable`=0, `write_addr`=0, `write_data`=0;
  - `owner`=0, `busy`=0, `rr_ptr`=0, burst counter 0, state ARB.
- Reset asserted mid-burst: the state returns to ARB immediately, asynchronously, and any pending output write is cancelled.
- `busy` is registered: high in the cycle after entry to LOCK and low in the cycle after exit.

## Configuration
- `REG_ARB_STATS_EN` defined adds:
  - `grant_count` out N_REQ*8: per-requester transfer counters, saturating at 255;
  - `drop_count` out 8: count of X0-address transfers, saturating.
  - All counters reset to 0.
- `REG_ARB_STATS_EN` undefined: these ports and counters are absent; all other behaviour is identical.

## Structure
- Shared package `regbank_pkg`:
  - `ADDR_W`/`DATA_W` defaults;
  - `X0_ADDR` = 3'd0;
  - `arb_state_t` enum {ARB, LOCK}.
- Sub-module `rr_pick`: combinational round-robin priority pick (valid vector + pointer → one-hot grant + index). Reused by the arbiter and future read-port arbitration.

## Test plan
- Reset, then requester 2 sends addr 3, data 8'hA5 → `req_ready[2]`=1 in the same cycle; next cycle `write_enable`=1, `write_addr`=3, `write_data`=8'hA5; the pulse lasts one cycle.
- All 4 requesters valid continuously, no lock → grants in order 0,1,2,3,0 on consecutive cycles; `write_enable` high every cycle.
- Requester 1 sends with lock=1 while 0 and 3 are valid, `LOCK_MAX`=8 → 8 consecutive grants to 1, then `busy` falls; the next grant goes to 3 (pointer 2, first valid from 2 upward).
- Requester 0 writes addr 0, data 8'hFF → handshake completes; `write_enable` stays 0; with `REG_ARB_STATS_EN`, `drop_count` goes to 1.
- Requester 2 locks, then `rst` is pulsed mid-burst → outputs 0 asynchronously, `busy`=0, state ARB; after release, the first grant goes to the lowest valid index (pointer 0).
- With `REG_ARB_STATS_EN`, 300 transfers from requester 1 → `grant_count[1]` saturates at 255.

Source files
------------

// File: rtl/regbank_pkg.sv
// regbank_pkg
//   Shared definitions for the register8_bank write-port arbitration slice.
//   - REGBANK_ADDR_W / REGBANK_DATA_W : default address / data widths
//   - X0_ADDR                         : hardwired-zero register address
//   - arb_state_t                     : arbiter FSM states (ARB, LOCK)
package regbank_pkg;

    localparam int REGBANK_ADDR_W = 3;
    localparam int REGBANK_DATA_W = 8;

    localparam logic [2:0] X0_ADDR = 3'd0;

    typedef enum logic {
        ARB  = 1'b0,
        LOCK = 1'b1
    } arb_state_t;

endpackage

// File: rtl/regbank_write_arbiter_rr_pick.sv
// rr_pick
//   Combinational round-robin priority pick. Scans the valid vector from
//   ptr upward with wrap-around and returns the first valid index.
//   Ports:
//     valid [N-1:0]  : request vector
//     ptr   [IW-1:0] : index with highest priority this cycle
//     grant [N-1:0]  : one-hot (or zero) grant
//     idx   [IW-1:0] : index of the granted bit (0 when nothing valid)
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  valid,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic          found;
    logic [IW-1:0] j;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        j     = '0;
        for (int unsigned k = 0; k < N; k++) begin
            j = IW'((32'(ptr) + k) % N);
            if (!found && valid[j]) begin
                found    = 1'b1;
                grant[j] = 1'b1;
                idx      = j;
            end
        end
    end

endmodule

// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter
//   Round-robin arbiter sharing the single write port of register8_bank
//   among N_REQ valid/ready requesters, with bounded locked bursts.
//   Writes to X0 complete the handshake but never pulse write_enable.
//   Ports:
//     clk, rst (async, active-high)
//     req_valid/req_lock [N_REQ]    : per-requester request / keep-port flag
//     req_addr/req_data (packed)    : slice i belongs to requester i
//     req_ready [N_REQ]             : one-hot-or-zero grant (combinational)
//     write_enable/addr/data        : registered bank write port
//     busy                          : registered, high while in LOCK
//     owner                         : last granted requester
//   Optional (`define REG_ARB_STATS_EN):
//     grant_count [N_REQ*8]         : saturating per-requester transfer counts
//     drop_count  [8]               : saturating count of X0 transfers
module regbank_write_arbiter
    import regbank_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int ADDR_W   = REGBANK_ADDR_W,
    parameter int DATA_W   = REGBANK_DATA_W,
    parameter int LOCK_MAX = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [N_REQ-1:0]          req_lock,
    input  logic [N_REQ*ADDR_W-1:0]   req_addr,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic                      write_enable,
    output logic [ADDR_W-1:0]         write_addr,
    output logic [DATA_W-1:0]         write_data,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  owner
`ifdef REG_ARB_STATS_EN
    ,
    output logic [N_REQ*8-1:0]        grant_count,
    output logic [7:0]                drop_count
`endif
);

    localparam int IW = $clog2(N_REQ);
    localparam int CW = $clog2(LOCK_MAX + 1);
    localparam logic [IW-1:0]     LAST_IDX  = IW'(N_REQ - 1);
    localparam logic [CW-1:0]     CNT_MAX   = CW'(LOCK_MAX);
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(X0_ADDR);

    arb_state_t        state;
    logic [IW-1:0]     rr_ptr;
    logic [CW-1:0]     burst_cnt;
    logic [CW-1:0]     cnt_next;
    logic [N_REQ-1:0]  pick_grant;
    logic [IW-1:0]     pick_idx;
    logic [IW-1:0]     xfer_idx;
    logic [IW-1:0]     next_ptr;
    logic              xfer;
    logic [ADDR_W-1:0] addr_arr [N_REQ];
    logic [DATA_W-1:0] data_arr [N_REQ];
    logic [ADDR_W-1:0] xfer_addr;
    logic [DATA_W-1:0] xfer_data;

    rr_pick #(.N(N_REQ)) u_pick (
        .valid (req_valid),
        .ptr   (rr_ptr),
        .grant (pick_grant),
        .idx   (pick_idx)
    );

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            addr_arr[i] = req_addr[i*ADDR_W +: ADDR_W];
            data_arr[i] = req_data[i*DATA_W +: DATA_W];
        end
    end

    // Ready depends only on state/pointer/owner/valid; addr/data never feed it.
    always_comb begin
        req_ready = '0;
        xfer_idx  = pick_idx;
        if (state == ARB) begin
            req_ready = pick_grant;
        end else begin
            xfer_idx         = owner;
            req_ready[owner] = req_valid[owner];
        end
    end

    assign xfer      = |(req_valid & req_ready);
    assign xfer_addr = addr_arr[xfer_idx];
    assign xfer_data = data_arr[xfer_idx];
    assign next_ptr  = (xfer_idx == LAST_IDX) ? '0 : xfer_idx + 1'b1;
    assign cnt_next  = burst_cnt + 1'b1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ARB;
            rr_ptr       <= '0;
            owner        <= '0;
            burst_cnt    <= '0;
            busy         <= 1'b0;
            write_enable <= 1'b0;
            write_addr   <= '0;
            write_data   <= '0;
        end else begin
            write_enable <= xfer && (xfer_addr != ZERO_ADDR);
            if (xfer) begin
                write_addr <= xfer_addr;
                write_data <= xfer_data;
                owner      <= xfer_idx;
                rr_ptr     <= next_ptr;
            end
            case (state)
                ARB: begin
                    if (xfer && req_lock[xfer_idx] && (LOCK_MAX > 1)) begin
                        state     <= LOCK;
                        busy      <= 1'b1;
                        burst_cnt <= CW'(1);
                    end
                end
                LOCK: begin
                    if (xfer) begin
                        if (!req_lock[owner] || cnt_next == CNT_MAX) begin
                            state     <= ARB;
                            busy      <= 1'b0;
                            burst_cnt <= '0;
                        end else begin
                            burst_cnt <= cnt_next;
                        end
                    end else if (!req_valid[owner] && !req_lock[owner]) begin
                        // rr_ptr already holds owner+1 from the owner's last transfer.
                        state     <= ARB;
                        busy      <= 1'b0;
                        burst_cnt <= '0;
                    end
                end
                default: begin
                    state <= ARB;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef REG_ARB_STATS_EN
    logic [7:0] gcnt [N_REQ];
    logic [7:0] dcnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < N_REQ; i++) begin
                gcnt[i] <= '0;
            end
            dcnt <= '0;
        end else if (xfer) begin
            if (gcnt[xfer_idx] != '1) begin
                gcnt[xfer_idx] <= gcnt[xfer_idx] + 8'd1;
            end
            if (xfer_addr == ZERO_ADDR && dcnt != '1) begin
                dcnt <= dcnt + 8'd1;
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_REQ; i++) begin
            grant_count[i*8 +: 8] = gcnt[i];
        end
    end

    assign drop_count = dcnt;
`endif

endmodule
